// File: rtl/counter_10000_pkg.sv
// Shared types and constants for the modulo-10000 display counter.
// Optional saturating build: define COUNTER_10000_SATURATE_EN.
package counter_10000_pkg;

  localparam int unsigned CNT_MAX = 10000;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_10000_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks, held low in reset.
// Used by counter_10000 (COUNTER_10000_SATURATE_EN has no effect here).
module tick_gen
  import counter_10000_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          hit;

  always_comb begin
    hit   = (pre_q == LAST);
    pre_d = hit ? '0 : pre_q + 1'b1;
  end

  // Gated by rst so tick reads 0 while reset is held.
  assign tick = hit & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_10000.sv
// Up/down modulo-MAX_COUNT counter feeding the FND display path.
// Define COUNTER_10000_SATURATE_EN to hold at the limits instead of wrapping.
module counter_10000
  import counter_10000_pkg::*;
#(
  parameter  int unsigned MAX_COUNT = CNT_MAX,
  parameter  int unsigned TICK_DIV  = 1,
  localparam int unsigned WIDTH     = $clog2(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] count_reg
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_COUNT - 1);

  logic             tick;
  dir_e             dir;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign dir = dir_e'(mode);

  always_comb begin
    count_d = count_q;
    at_top  = (count_q == TOP);
    at_bot  = (count_q == '0);
    if (tick) begin
      unique case (1'b1)
        (dir == DIR_UP): begin
`ifdef COUNTER_10000_SATURATE_EN
          count_d = at_top ? count_q : count_q + 1'b1;
`else
          count_d = at_top ? '0 : count_q + 1'b1;
`endif
        end
        (dir == DIR_DOWN): begin
`ifdef COUNTER_10000_SATURATE_EN
          count_d = at_bot ? count_q : count_q - 1'b1;
`else
          count_d = at_bot ? TOP : count_q - 1'b1;
`endif
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_reg = count_q;

endmodule

// File: tb/tb_counter_10000.sv
// Scoreboard bench: two DUTs (TICK_DIV=1 and TICK_DIV=4) against an arithmetic model.
// Follows COUNTER_10000_SATURATE_EN when the build defines it.
module tb_counter_10000;

  localparam int MAXC = 10000;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [13:0] cnt1;
  logic [13:0] cnt4;

  counter_10000 #(
    .MAX_COUNT (MAXC),
    .TICK_DIV  (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .count_reg (cnt1)
  );

  counter_10000 #(
    .MAX_COUNT (MAXC),
    .TICK_DIV  (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .count_reg (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int e1;
    int e4;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: value and edges seen since reset release.
  int v1 = 0;
  int v4 = 0;
  int edges = 0;

  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  function automatic int next_val(int v, bit up);
`ifdef COUNTER_10000_SATURATE_EN
    if (up) return (v == MAXC - 1) ? v : v + 1;
    return (v == 0) ? 0 : v - 1;
`else
    if (up) return (v + 1) % MAXC;
    return (v + MAXC - 1) % MAXC;
`endif
  endfunction

  function automatic void model_reset();
    v1 = 0;
    v4 = 0;
    edges = 0;
  endfunction

  // One clock with given inputs; the model sees what the DUT samples.
  task automatic step(bit r, bit m);
    exp_t e;
    rst  = r;
    mode = m;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      edges++;
      v1 = next_val(v1, m);
      if (edges % 4 == 0) v4 = next_val(v4, m);
    end
    e.e1 = v1;
    e.e4 = v4;
    exp_q.push_back(e);
    #2;
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic async_reset(string name);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk({name, "_div1"}, int'(cnt1), 0);
    chk({name, "_div4"}, int'(cnt4), 0);
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cnt_div1", int'(cnt1), e.e1);
      chk("cnt_div4", int'(cnt4), e.e4);
    end
  end

  initial begin
    rst  = 1'b1;
    mode = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset_immediate_div1", int'(cnt1), 0);
    chk("reset_immediate_div4", int'(cnt4), 0);
    model_reset();
    repeat (3) step(1'b0, 1'b1);

    // Up through the wrap (or saturation), then a turn downward.
    repeat (10001) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);

    // Down from reset.
    async_reset("reset_down");
    step(1'b0, 1'b0);
    repeat (10000) step(1'b1, 1'b0);

    // Direction changes around small values.
    async_reset("reset_dir");
    step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);

    // Prescaled counter reaches 7, then reset mid-count.
    begin
      int guard = 0;
      while (v4 != 7 && guard < 200) begin
        step(1'b1, 1'b1);
        guard++;
      end
      chk("reach_div4_7", v4, 7);
    end
    async_reset("reset_mid");
    step(1'b0, 1'b1);
    repeat (12) step(1'b1, 1'b1);

    // Random direction with occasional resets.
    repeat (3000) begin
      bit r = ($urandom_range(0, 199) != 0);
      bit m = 1'($urandom_range(0, 1));
      step(r, m);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_10000.md
Name: counter_10000

Overview:
- Free-running modulo-10000 counter, BCD-free binary value 0..9999.
- Selectable up/down direction.
- Feeds the FND (7-segment) display path, which splits the value into four decimal digits.
- Counts on an internal tick derived from the system clock by an optional prescaler.

Parameters:
- MAX_COUNT, 10000, modulus; count range is 0..MAX_COUNT-1.
- TICK_DIV, 1, clock cycles per count step; 1 means step every clock; legal range 1..2^32-1.
- WIDTH, $clog2(MAX_COUNT) (=14), width of count_reg; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset (rst=0 resets).
- mode  input  1  direction: 1 = up, 0 = down.
- count_reg  output  WIDTH (14)  current count, driven directly from a flop.

Behaviour:
- One clock, clk. rst is asynchronous, active-low.
- Reset values (rst low, immediate, no clock needed):
  - count_reg = 0.
  - Prescaler counter = 0.
  - Tick = 0.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1.
  - tick=1 for exactly one clk cycle when the prescaler equals TICK_DIV-1, then the prescaler returns to 0.
  - With TICK_DIV=1, tick is constantly 1 out of reset.
- Count update on a clk edge with tick=1:
  - mode=1: count_reg <= (count_reg==MAX_COUNT-1) ? 0 : count_reg+1.
  - mode=0: count_reg <= (count_reg==0) ? MAX_COUNT-1 : count_reg-1.
- No tick: count_reg holds.
- Latency:
  - count_reg changes on the same edge that samples tick. There is no extra pipeline.
  - First increment after reset release (TICK_DIV=1) happens on the first rising clk edge with rst=1.
- mode is sampled only on tick edges. A mode change between ticks affects the next step only, with no glitch or skip.
- Values >= MAX_COUNT are never produced.
- Wrap boundaries:
  - Up: 9999 -> 0.
  - Down: 0 -> 9999.
- Reset asserted mid-count: count_reg goes to 0 asynchronously. The prescaler restarts, so the first step after release occurs TICK_DIV edges later.
- No enable or clear inputs: the counter always runs when out of reset.

Optional Feature:
- Macro: COUNTER_10000_SATURATE_EN.
- Defined: no wrap.
  - Up holds at MAX_COUNT-1 (9999).
  - Down holds at 0.
  - Stepping resumes as soon as the direction moves away from the limit.
- Undefined (default): modulo wrap as in Behaviour.
- Ports and reset behaviour are identical in both builds.

Decomposition:
- Package counter_10000_pkg:
  - localparam CNT_MAX = 10000.
  - localparam CNT_W = $clog2(CNT_MAX).
  - typedef logic [CNT_W-1:0] count_t.
  - Direction enum dir_e {DIR_DOWN=1'b0, DIR_UP=1'b1}.
- One sub-module, tick_gen:
  - Parameter DIV.
  - Ports clk, rst (async active-low), tick.
- counter_10000 instantiates tick_gen and holds the count register and next-state logic.

Test Plan:
- Reset: hold rst=0 for 3 clocks with mode=1 -> count_reg=0 throughout, including immediately on rst falling mid-cycle.
- Up count (TICK_DIV=1, mode=1): release rst -> count_reg=1 after 1st edge, 100 after 100 edges, 9999 after 9999 edges, 0 on edge 10000, 1 on edge 10001.
- Down count (mode=0): release rst -> first edge gives 9999, then 9998; after 10000 edges back at 0.
- Direction change: count up to 5, set mode=0 -> next edge gives 4, then 3; set mode=1 at 3 -> next edge gives 4.
- Prescaler (TICK_DIV=4, mode=1): count_reg steps 0->1 on the 4th edge after release and changes every 4 edges thereafter. Assert reset at count 7 -> count_reg=0 and the next step occurs 4 edges after release.
- Saturate build (COUNTER_10000_SATURATE_EN):
  - Up to 9999, further edges -> stays 9999.
  - mode=0 -> 9998.
  - Down from reset -> stays 0.
